// File: rtl/core_mem_pkg.sv
// Shared types and constants for the core memory-port arbiter and its
// winner-select helper.
package core_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    PICK_NONE = 2'd0,
    PICK_IMEM = 2'd1,
    PICK_DMEM = 2'd2
  } pick_t;

  localparam logic [1:0] ARB_OWNER_NONE = 2'b00;
  localparam logic [1:0] ARB_OWNER_IMEM = 2'b01;
  localparam logic [1:0] ARB_OWNER_DMEM = 2'b10;

  localparam int MEM_ADDR_W_DEF = 64;
  localparam int MEM_DATA_W_DEF = 64;
  localparam int MEM_STRB_W_DEF = MEM_DATA_W_DEF / 8;

  localparam int STARVE_CNT_W   = 4;
  localparam int STARVE_MAX_DEF = 4;

  // Externally visible owner code for a registered arbiter state.
  function automatic logic [1:0] owner_code(input arb_state_t s);
    logic [1:0] code;
    case (s)
      OWN_I:   code = ARB_OWNER_IMEM;
      OWN_D:   code = ARB_OWNER_DMEM;
      default: code = ARB_OWNER_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/core_mem_arb_pick.sv
// Combinational winner select: data side has priority unless the instruction
// side has been passed over STARVE_MAX times in a row.
module core_mem_arb_pick
  import core_mem_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                    imem_req,
  input  logic                    dmem_req,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  output pick_t                   winner
);

  logic force_imem;

  always_comb begin
    force_imem = imem_req && (starve_cnt == STARVE_CNT_W'(STARVE_MAX));
    winner     = PICK_NONE;
    if (dmem_req && !force_imem) begin
      winner = PICK_DMEM;
    end else if (imem_req) begin
      winner = PICK_IMEM;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store. Ownership
// is locked for a whole transaction; arbitration happens only in IDLE.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
  parameter int MEM_STRB_W = MEM_STRB_W_DEF,
  parameter int MEM_DATA_W = MEM_DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  imem_req,
  input  logic [MEM_ADDR_W-1:0] imem_addr,
  input  logic                  imem_wen,
  input  logic [MEM_STRB_W-1:0] imem_strb,
  input  logic [MEM_DATA_W-1:0] imem_wdata,
  output logic                  imem_gnt,
  output logic                  imem_err,
  output logic [MEM_DATA_W-1:0] imem_rdata,

  input  logic                  dmem_req,
  input  logic [MEM_ADDR_W-1:0] dmem_addr,
  input  logic                  dmem_wen,
  input  logic [MEM_STRB_W-1:0] dmem_strb,
  input  logic [MEM_DATA_W-1:0] dmem_wdata,
  output logic                  dmem_gnt,
  output logic                  dmem_err,
  output logic [MEM_DATA_W-1:0] dmem_rdata,

  output logic                  mem_req,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [MEM_STRB_W-1:0] mem_strb,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_err,
  input  logic [MEM_DATA_W-1:0] mem_rdata,

  output logic [1:0]            arb_owner
);

  arb_state_t              state, state_next;
  logic [STARVE_CNT_W-1:0] starve_cnt, starve_cnt_next;
  pick_t                   winner;
  pick_t                   sel;

  core_mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .imem_req   (imem_req),
    .dmem_req   (dmem_req),
    .starve_cnt (starve_cnt),
    .winner     (winner)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // A zero-wait grant in IDLE completes the transaction without taking ownership.
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    case (state)
      IDLE: begin
        if (winner == PICK_IMEM) begin
          starve_cnt_next = '0;
        end else if (winner == PICK_DMEM && imem_req &&
                     starve_cnt < STARVE_CNT_W'(STARVE_MAX)) begin
          starve_cnt_next = starve_cnt + STARVE_CNT_W'(1);
        end
        if (!mem_gnt) begin
          case (winner)
            PICK_IMEM: state_next = OWN_I;
            PICK_DMEM: state_next = OWN_D;
            default:   state_next = IDLE;
          endcase
        end
      end
      OWN_I, OWN_D: begin
        if (mem_gnt) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (state)
      IDLE:    sel = winner;
      OWN_I:   sel = PICK_IMEM;
      OWN_D:   sel = PICK_DMEM;
      default: sel = PICK_NONE;
    endcase

    mem_req   = 1'b0;
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_strb  = '0;
    mem_wdata = '0;
    case (sel)
      PICK_IMEM: begin
        mem_req   = imem_req;
        mem_addr  = imem_addr;
        mem_wen   = imem_wen;
        mem_strb  = imem_strb;
        mem_wdata = imem_wdata;
      end
      PICK_DMEM: begin
        mem_req   = dmem_req;
        mem_addr  = dmem_addr;
        mem_wen   = dmem_wen;
        mem_strb  = dmem_strb;
        mem_wdata = dmem_wdata;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase

    // Nothing is forwarded or completed while reset is held; the memory side resets too.
    if (reset) begin
      mem_req = 1'b0;
    end

    imem_gnt   = mem_gnt && !reset && (sel == PICK_IMEM);
    dmem_gnt   = mem_gnt && !reset && (sel == PICK_DMEM);
    imem_err   = imem_gnt && mem_err;
    dmem_err   = dmem_gnt && mem_err;
    imem_rdata = imem_gnt ? mem_rdata : '0;
    dmem_rdata = dmem_gnt ? mem_rdata : '0;

    arb_owner  = owner_code(state);
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Self-checking bench for core_mem_arbiter: directed scenarios followed by
// randomized requester/memory traffic, all checked against a behavioural model.
module tb_core_mem_arbiter;

  localparam int AW   = 64;
  localparam int SW   = 8;
  localparam int DW   = 64;
  localparam int SMAX = 4;

  logic          clock;
  logic          reset;
  logic          imem_req, imem_wen, imem_gnt, imem_err;
  logic [AW-1:0] imem_addr;
  logic [SW-1:0] imem_strb;
  logic [DW-1:0] imem_wdata, imem_rdata;
  logic          dmem_req, dmem_wen, dmem_gnt, dmem_err;
  logic [AW-1:0] dmem_addr;
  logic [SW-1:0] dmem_strb;
  logic [DW-1:0] dmem_wdata, dmem_rdata;
  logic          mem_req, mem_wen, mem_gnt, mem_err;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_strb;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [1:0]    arb_owner;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: who holds the port (0 none, 1 imem, 2 dmem) and how many
  // times in a row dmem has beaten a waiting imem.
  int   m_owner  = 0;
  int   m_streak = 0;
  int   m_win    = 0;
  logic exp_igrant, exp_dgrant;

  core_mem_arbiter #(
    .MEM_ADDR_W (AW),
    .MEM_STRB_W (SW),
    .MEM_DATA_W (DW),
    .STARVE_MAX (SMAX)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_wen   (imem_wen),
    .imem_strb  (imem_strb),
    .imem_wdata (imem_wdata),
    .imem_gnt   (imem_gnt),
    .imem_err   (imem_err),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_addr  (dmem_addr),
    .dmem_wen   (dmem_wen),
    .dmem_strb  (dmem_strb),
    .dmem_wdata (dmem_wdata),
    .dmem_gnt   (dmem_gnt),
    .dmem_err   (dmem_err),
    .dmem_rdata (dmem_rdata),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wen    (mem_wen),
    .mem_strb   (mem_strb),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_err    (mem_err),
    .mem_rdata  (mem_rdata),
    .arb_owner  (arb_owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic compare(input string tag, input string what,
                         input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, what, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic ireq, input logic [63:0] iaddr, input logic iwen,
                               input logic dreq, input logic [63:0] daddr, input logic dwen,
                               input logic mgnt, input logic merr, input logic [63:0] mrd);
    reset      = rst;
    imem_req   = ireq;
    imem_addr  = iaddr;
    imem_wen   = iwen;
    imem_strb  = iaddr[7:0] ^ 8'h5A;
    imem_wdata = ~iaddr;
    dmem_req   = dreq;
    dmem_addr  = daddr;
    dmem_wen   = dwen;
    dmem_strb  = daddr[7:0] ^ 8'hA5;
    dmem_wdata = {daddr[31:0], daddr[63:32]};
    mem_gnt    = mgnt;
    mem_err    = merr;
    mem_rdata  = mrd;
  endtask

  // Settle, then compare every DUT output with what the model expects this cycle.
  task automatic checkOutput(input string tag);
    logic exp_mreq;
    #3;
    if (reset)                 m_win = 0;
    else if (m_owner != 0)     m_win = m_owner;
    else if (dmem_req && !(imem_req && m_streak == SMAX)) m_win = 2;
    else if (imem_req)         m_win = 1;
    else                       m_win = 0;

    exp_mreq   = (m_win == 1) ? imem_req : (m_win == 2) ? dmem_req : 1'b0;
    exp_igrant = (m_win == 1) && mem_gnt;
    exp_dgrant = (m_win == 2) && mem_gnt;

    compare(tag, "mem_req", 64'(mem_req), 64'(exp_mreq));
    if (exp_mreq && m_win == 1) begin
      compare(tag, "mem_addr", mem_addr, imem_addr);
      compare(tag, "mem_wen", 64'(mem_wen), 64'(imem_wen));
      compare(tag, "mem_strb", 64'(mem_strb), 64'(imem_strb));
      compare(tag, "mem_wdata", mem_wdata, imem_wdata);
    end else if (exp_mreq && m_win == 2) begin
      compare(tag, "mem_addr", mem_addr, dmem_addr);
      compare(tag, "mem_wen", 64'(mem_wen), 64'(dmem_wen));
      compare(tag, "mem_strb", 64'(mem_strb), 64'(dmem_strb));
      compare(tag, "mem_wdata", mem_wdata, dmem_wdata);
    end
    compare(tag, "imem_gnt", 64'(imem_gnt), 64'(exp_igrant));
    compare(tag, "dmem_gnt", 64'(dmem_gnt), 64'(exp_dgrant));
    compare(tag, "imem_err", 64'(imem_err), 64'(exp_igrant && mem_err));
    compare(tag, "dmem_err", 64'(dmem_err), 64'(exp_dgrant && mem_err));
    compare(tag, "imem_rdata", imem_rdata, exp_igrant ? mem_rdata : 64'h0);
    compare(tag, "dmem_rdata", dmem_rdata, exp_dgrant ? mem_rdata : 64'h0);
    if (!reset) begin
      compare(tag, "arb_owner", 64'(arb_owner), 64'(m_owner));
    end
  endtask

  // Advance one clock and move the model along with the inputs seen at the edge.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      m_owner  = 0;
      m_streak = 0;
    end else begin
      if (m_owner == 0 && m_win == 1) begin
        m_streak = 0;
      end else if (m_owner == 0 && m_win == 2 && imem_req && m_streak < SMAX) begin
        m_streak++;
      end
      m_owner = mem_gnt ? 0 : m_win;
    end
    #1;
  endtask

  logic          rnd_rst;
  logic          i_pend, i_wen, d_pend, d_wen;
  logic [63:0]   i_addr, d_addr;
  int            dmem_before_imem;
  logic          imem_seen;

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset");
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("reset_idle");
    compare("reset_idle", "arb_owner_const", 64'(arb_owner), 64'd0);
    compare("reset_idle", "mem_req_const", 64'(mem_req), 64'd0);
    tick();

    // Single imem read with two wait cycles
    applyStimulus(0, 1, 64'h80, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("imem_rd_c1");
    compare("imem_rd_c1", "mem_addr_const", mem_addr, 64'h80);
    tick();
    applyStimulus(0, 1, 64'h80, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("imem_rd_c2");
    compare("imem_rd_c2", "arb_owner_const", 64'(arb_owner), 64'd1);
    tick();
    applyStimulus(0, 1, 64'h80, 0, 0, 0, 0, 1, 0, 64'hDEAD);
    checkOutput("imem_rd_c3");
    compare("imem_rd_c3", "imem_gnt_const", 64'(imem_gnt), 64'd1);
    compare("imem_rd_c3", "imem_rdata_const", imem_rdata, 64'hDEAD);
    compare("imem_rd_c3", "dmem_gnt_const", 64'(dmem_gnt), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("imem_rd_c4");
    compare("imem_rd_c4", "imem_gnt_const", 64'(imem_gnt), 64'd0);
    tick();

    // Simultaneous requests: dmem first, imem on the next arbitration
    applyStimulus(0, 1, 64'h100, 0, 1, 64'h200, 1, 1, 0, 64'h1111);
    checkOutput("simul_c1");
    compare("simul_c1", "mem_addr_const", mem_addr, 64'h200);
    compare("simul_c1", "dmem_gnt_const", 64'(dmem_gnt), 64'd1);
    tick();
    applyStimulus(0, 1, 64'h100, 0, 0, 0, 0, 1, 0, 64'h2222);
    checkOutput("simul_c2");
    compare("simul_c2", "mem_addr_const", mem_addr, 64'h100);
    compare("simul_c2", "imem_rdata_const", imem_rdata, 64'h2222);
    tick();

    // Starvation bound: imem held, dmem back-to-back with zero-wait grants
    dmem_before_imem = 0;
    imem_seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 1, 64'h300, 0, 1, 64'h400 + 64'(k), 1, 1, 0, 64'(k));
      checkOutput("starve");
      if (k == SMAX || k == 2 * SMAX + 1) begin
        compare("starve", "imem_gnt_turn", 64'(imem_gnt), 64'd1);
      end else begin
        compare("starve", "dmem_gnt_turn", 64'(dmem_gnt), 64'd1);
      end
      if (!imem_seen && dmem_gnt) dmem_before_imem++;
      if (imem_gnt) imem_seen = 1'b1;
      tick();
    end
    compare("starve", "dmem_wins_before_imem", 64'(dmem_before_imem), 64'(SMAX));

    // Error routing on a dmem store
    applyStimulus(0, 0, 0, 0, 1, 64'h500, 1, 0, 0, 0);
    checkOutput("err_c1");
    tick();
    applyStimulus(0, 0, 0, 0, 1, 64'h500, 1, 1, 1, 64'h77);
    checkOutput("err_c2");
    compare("err_c2", "dmem_err_const", 64'(dmem_err), 64'd1);
    compare("err_c2", "imem_err_const", 64'(imem_err), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("err_c3");
    compare("err_c3", "arb_owner_const", 64'(arb_owner), 64'd0);
    tick();

    // Reset in the middle of a dmem transaction
    applyStimulus(0, 0, 0, 0, 1, 64'h600, 1, 0, 0, 0);
    checkOutput("rst_mid_c1");
    tick();
    applyStimulus(0, 0, 0, 0, 1, 64'h600, 1, 0, 0, 0);
    checkOutput("rst_mid_c2");
    compare("rst_mid_c2", "arb_owner_const", 64'(arb_owner), 64'd2);
    tick();
    applyStimulus(1, 0, 0, 0, 1, 64'h600, 1, 1, 1, 64'h99);
    checkOutput("rst_mid_c3");
    compare("rst_mid_c3", "dmem_gnt_const", 64'(dmem_gnt), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_mid_c4");
    compare("rst_mid_c4", "arb_owner_const", 64'(arb_owner), 64'd0);
    compare("rst_mid_c4", "mem_req_const", 64'(mem_req), 64'd0);
    tick();

    // Zero-wait imem grant stays in IDLE
    applyStimulus(0, 1, 64'h700, 0, 0, 0, 0, 1, 0, 64'hBEEF);
    checkOutput("zero_wait_c1");
    compare("zero_wait_c1", "imem_gnt_const", 64'(imem_gnt), 64'd1);
    compare("zero_wait_c1", "arb_owner_const", 64'(arb_owner), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("zero_wait_c2");
    compare("zero_wait_c2", "arb_owner_const", 64'(arb_owner), 64'd0);
    tick();

    // Stray grant with nothing requested
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h55);
    checkOutput("stray_gnt");
    tick();

    // Randomized traffic with protocol-abiding requesters
    i_pend = 1'b0; d_pend = 1'b0;
    i_wen  = 1'b0; d_wen  = 1'b0;
    i_addr = '0;   d_addr = '0;
    for (int c = 0; c < 600; c++) begin
      rnd_rst = ($urandom_range(0, 63) == 0);
      if (!i_pend && $urandom_range(0, 1) == 1) begin
        i_pend = 1'b1;
        i_addr = {$urandom, $urandom};
        i_wen  = 1'($urandom_range(0, 1));
      end
      if (!d_pend && $urandom_range(0, 1) == 1) begin
        d_pend = 1'b1;
        d_addr = {$urandom, $urandom};
        d_wen  = 1'($urandom_range(0, 1));
      end
      applyStimulus(rnd_rst, i_pend, i_addr, i_wen, d_pend, d_addr, d_wen,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    {$urandom, $urandom});
      checkOutput("random");
      if (exp_igrant || rnd_rst) i_pend = 1'b0;
      if (exp_dgrant || rnd_rst) d_pend = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares one memory port between the core's instruction-fetch (imem) and load/store (dmem) requesters, for single-port memory systems and the formal environment. It sits between `core_top` and the memory or bus model. It uses the same req/gnt/err/rdata protocol on every port. Arbitration is dmem-priority, with a bounded-starvation guarantee for imem. Ownership is locked for the whole of a transaction.

## Interface
Parameters:
- `MEM_ADDR_W`, 64: address width.
- `MEM_STRB_W`, 8: write strobe width.
- `MEM_DATA_W`, 64: data width.
- `STARVE_MAX`, 4: number of consecutive dmem wins, while imem is waiting, after which imem is forced to win. Legal range 1..15.

Ports:
- `clock`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `imem_req`, `imem_addr`, `imem_wen`, `imem_strb`, `imem_wdata`: in. Instruction requester request fields; widths 1/ADDR/1/STRB/DATA.
- `imem_gnt`, `imem_err`, `imem_rdata`: out. Instruction requester response; widths 1/1/DATA.
- `dmem_req`, `dmem_addr`, `dmem_wen`, `dmem_strb`, `dmem_wdata`: in. Data requester request fields; same widths as imem.
- `dmem_gnt`, `dmem_err`, `dmem_rdata`: out. Data requester response; widths 1/1/DATA.
- `mem_req`, `mem_addr`, `mem_wen`, `mem_strb`, `mem_wdata`: out. Shared downstream request.
- `mem_gnt`, `mem_err`, `mem_rdata`: in. Shared downstream response.
- `arb_owner`, out, 2: current owner. 00 = none, 01 = imem, 10 = dmem.

## Operation
Protocol (all ports):
- A request is `req`=1 with its fields. The requester holds `req` and all fields stable until it sees `gnt`=1.
- `gnt` is a single-cycle pulse. It marks completion; `rdata` and `err` are valid in that same cycle.
- `req` may stay high into the next cycle to start a back-to-back request.

FSM states: IDLE, OWN_I, OWN_D.
- **IDLE:**
  - The winner is chosen combinationally and forwarded to `mem_*` in the same cycle.
  - Winner is dmem if `dmem_req`=1, unless `starve_cnt` = `STARVE_MAX` and `imem_req`=1, in which case the winner is imem.
  - Otherwise the winner is imem if `imem_req`=1. With no request, `mem_req`=0.
  - If `mem_gnt` returns in the same cycle, the transaction completes and the FSM stays in IDLE. Otherwise the FSM moves to OWN_I or OWN_D according to the winner.
- **OWN_x:**
  - `mem_*` is driven only from the owner's fields. The other requester is never forwarded.
  - On `mem_gnt`=1 the FSM returns to IDLE.
  - A new arbitration occurs in the next cycle, even if the owner keeps `req` high. This guarantees one transaction per grant.
- **Response routing:**
  - `x_gnt` = `mem_gnt` AND (owner is x, or the IDLE winner is x).
  - `x_rdata` = `mem_rdata`, and `x_err` = `mem_err`, gated to 0 when `x_gnt`=0.
  - The non-owner always sees gnt=0, err=0, rdata=0.
- **Starvation counter:** `starve_cnt` is 4 bits.
  - Increments on each dmem arbitration win while `imem_req`=1.
  - Clears to 0 on each imem arbitration win.
  - Holds otherwise. It never exceeds `STARVE_MAX`.
- `mem_err` does not change arbitration. The error is routed to the owner and the transaction still completes.

## Timing
- Reset values: state=IDLE, `starve_cnt`=0, owner=none. Consequently `mem_req`=0, all `x_gnt`/`x_err`=0, all rdata=0, and `arb_owner`=00.
- Zero added latency: a request issued in IDLE appears on `mem_*` in the same cycle, and `mem_gnt` reaches the requester combinationally in the same cycle.
- Arbitration occurs only in IDLE, so there is at most one IDLE cycle between back-to-back transactions.
- Simultaneous requests in IDLE resolve to dmem unless the starvation rule applies.
- Worst-case imem wait is `STARVE_MAX`+1 dmem transactions.
- Reset asserted mid-transaction:
  - The FSM returns to IDLE on the next edge and the outstanding downstream transaction is abandoned. The memory side is reset by the same `reset`.
  - A `mem_gnt` seen in the reset cycle is not routed to either requester.
- A `mem_gnt` arriving in IDLE with `mem_req`=0 is ignored: no requester gnt is raised.
- `arb_owner` reflects the registered owner. In IDLE it reads 00, even while a combinational forward is in progress.

## Structure
- Shared package `core_mem_pkg`:
  - `arb_state_t` enum (IDLE, OWN_I, OWN_D).
  - `ARB_OWNER_*` encodings.
  - Width localparams derived from the `MEM_*` parameters.
- One sub-module, `core_mem_arb_pick`: combinational priority plus starvation select. It takes `imem_req`, `dmem_req` and `starve_cnt`, and produces the winner. It is reusable for a later MMIO/RAM split.
- The main module holds the FSM, the counter, and the request/response muxing.

## Test plan
- **Single imem read:** `imem_req`=1, addr=0x80, `mem_gnt` after 2 cycles with rdata=0xDEAD → `imem_gnt`=1 for one cycle with rdata=0xDEAD; `dmem_gnt` stays 0; `arb_owner`=01 during the wait.
- **Simultaneous requests:** both req=1 in the same cycle → `mem_addr`=dmem_addr first; imem is served on the following arbitration.
- **Starvation bound:** `imem_req` held, dmem back-to-back, `STARVE_MAX`=4 → exactly 4 dmem grants, then one imem grant, then `starve_cnt`=0.
- **Error routing:** dmem store with `mem_err`=1 on completion → `dmem_err`=1 with `dmem_gnt`; `imem_err`=0; the FSM returns to IDLE.
- **Reset mid-transaction:** `reset` in OWN_D before `mem_gnt` → next cycle state=IDLE, `mem_req`=0, all outputs at their reset values; `mem_gnt`=1 in the reset cycle produces no `dmem_gnt`.
- **Zero-wait gnt:** `mem_gnt`=1 in the same cycle as `imem_req` → `imem_gnt` in the same cycle, the FSM stays in IDLE, `arb_owner` stays 00.
